stopwatch_core: RTL and testbench
=================================

Name: stopwatch_core

Overview:
- Consumer end of the 100 ms divider output.
- Takes the divider's square-wave `tick_in`, detects its rising edges, and advances a BCD mm:ss.t time count while running.
- Start/stop and clear control comes from pre-debounced push-button levels.
- Outputs feed the seven-segment scan driver directly.

Parameters:
- SYNC_STAGES, 2: synchronizer flops on each asynchronous input (`tick_in`, `btn_start`, `btn_clear`); legal values 2 or 3.
- MIN_LIMIT, 59: highest minutes value before wrap; legal range 1..99.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- tick_in  input  1  divider square wave; each rising edge is one 100 ms count request.
- btn_start  input  1  debounced start/stop level; each rising edge toggles run/pause.
- btn_clear  input  1  debounced clear level; each rising edge zeroes the count and stops.
- tenths  output  4  BCD tenths of a second, 0..9.
- sec_ones  output  4  BCD seconds ones, 0..9.
- sec_tens  output  4  BCD seconds tens, 0..5.
- min_ones  output  4  BCD minutes ones, 0..9.
- min_tens  output  4  BCD minutes tens, 0..9 (bounded by MIN_LIMIT).
- running  output  1  high when state is RUN.
- wrap  output  1  one-cycle pulse when the count rolls over from the maximum to zero.

Behaviour:
- Reset (rst_n low, asynchronous): all digits 0, running 0, wrap 0, state IDLE, all synchronizer and edge flops 0. Release is synchronous to the next clk edge.
- Input conditioning:
  - Each input passes through SYNC_STAGES flops, then a one-flop delayed copy.
  - An edge event is sync_out & ~delayed.
  - With SYNC_STAGES=2, an input rising before clk edge k gives an event during the cycle after edge k+1. Its registered effect appears after edge k+2.
  - Input high pulses shorter than one clk period are not guaranteed to be seen.
- States, 2-bit encoding: IDLE=00, RUN=01, PAUSE=10.
  - IDLE: digits zero, not counting.
  - RUN: counting.
  - PAUSE: digits held.
- Transitions, evaluated each cycle; clear has priority over start:
  - clear event from any state -> IDLE; all digits := 0 in the same edge.
  - start event, IDLE -> RUN.
  - start event, RUN -> PAUSE.
  - start event, PAUSE -> RUN.
  - No event: stay in the current state.
- Counting:
  - Happens only when the current (pre-edge) state is RUN, a tick event is present and there is no clear event.
  - A tick coinciding with a start event in RUN is counted; the state then goes to PAUSE.
  - A tick coinciding with a start event in IDLE or PAUSE is not counted.
- Increment, BCD ripple within one cycle:
  - tenths 9->0 carries into sec_ones.
  - sec_ones 9->0 carries into sec_tens.
  - sec_tens 5->0 carries into minutes.
  - Minutes are a two-digit BCD value 00..MIN_LIMIT.
- Wrap:
  - At MIN_LIMIT:59.9 the next count gives 00:00.0, asserts wrap for exactly one cycle and keeps state RUN.
  - wrap is registered and coincides with the zeroed digits.
- running is registered and equals (state==RUN).
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset asserted mid-count forces all outputs to 0 immediately, without waiting for clk.

Test Plan:
- Reset, release, start edge, 10 tick_in rising edges -> running=1; digits 00:01.0; each digit update occurs 3 clk edges after the tick_in rise.
- Preload by counting to 00:59.9, one more tick -> 01:00.0; wrap stays 0.
- MIN_LIMIT=59, run to 59:59.9, one tick -> 00:00.0; wrap high exactly one cycle; running stays 1.
- Running at 00:03.4: start edge (pause), 5 ticks -> held at 00:03.4. Then start edge, 2 ticks -> 00:03.6.
- Tick event and clear event in the same cycle while RUN at 00:07.2 -> digits 00:00.0, state IDLE, running=0. A subsequent tick does not change the digits.
- rst_n pulled low between clk edges while RUN at 00:12.5 -> all outputs 0 before the next clk edge. After release, a tick without a start edge leaves the digits at 0.

Source files
------------

// File: rtl/stopwatch_core.sv
// stopwatch_core: BCD mm:ss.t stopwatch driven by the 100 ms divider tick.
// Inputs are synchronized and rising-edge detected; start toggles run/pause,
// clear zeroes the count and returns to IDLE. All outputs are registered.
module stopwatch_core #(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_LIMIT   = 59
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_in,
    input  logic       btn_start,
    input  logic       btn_clear,
    output logic [3:0] tenths,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       wrap
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_e;

    // Last legal minutes value split into its two BCD digits.
    localparam logic [3:0] MIN_TENS_MAX = 4'(MIN_LIMIT / 10);
    localparam logic [3:0] MIN_ONES_MAX = 4'(MIN_LIMIT % 10);

    logic [SYNC_STAGES-1:0] tick_sync_q;
    logic [SYNC_STAGES-1:0] start_sync_q;
    logic [SYNC_STAGES-1:0] clear_sync_q;
    logic                   tick_dly_q;
    logic                   start_dly_q;
    logic                   clear_dly_q;
    logic                   tick_evt;
    logic                   start_evt;
    logic                   clear_evt;

    state_e     state_q,    state_d;
    logic [3:0] tenths_q,   tenths_d;
    logic [3:0] sec_ones_q, sec_ones_d;
    logic [3:0] sec_tens_q, sec_tens_d;
    logic [3:0] min_ones_q, min_ones_d;
    logic [3:0] min_tens_q, min_tens_d;
    logic       wrap_q,     wrap_d;
    logic       running_q;

    // Synchronizer chains plus one delayed copy per input for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_sync_q  <= '0;
            start_sync_q <= '0;
            clear_sync_q <= '0;
            tick_dly_q   <= 1'b0;
            start_dly_q  <= 1'b0;
            clear_dly_q  <= 1'b0;
        end else begin
            tick_sync_q  <= {tick_sync_q[SYNC_STAGES-2:0],  tick_in};
            start_sync_q <= {start_sync_q[SYNC_STAGES-2:0], btn_start};
            clear_sync_q <= {clear_sync_q[SYNC_STAGES-2:0], btn_clear};
            tick_dly_q   <= tick_sync_q[SYNC_STAGES-1];
            start_dly_q  <= start_sync_q[SYNC_STAGES-1];
            clear_dly_q  <= clear_sync_q[SYNC_STAGES-1];
        end
    end

    assign tick_evt  = tick_sync_q[SYNC_STAGES-1]  & ~tick_dly_q;
    assign start_evt = start_sync_q[SYNC_STAGES-1] & ~start_dly_q;
    assign clear_evt = clear_sync_q[SYNC_STAGES-1] & ~clear_dly_q;

    // Next state and next count: clear wins, then count (pre-edge RUN only), then start toggle.
    always_comb begin
        state_d    = state_q;
        tenths_d   = tenths_q;
        sec_ones_d = sec_ones_q;
        sec_tens_d = sec_tens_q;
        min_ones_d = min_ones_q;
        min_tens_d = min_tens_q;
        wrap_d     = 1'b0;
        if (clear_evt) begin
            state_d    = ST_IDLE;
            tenths_d   = 4'd0;
            sec_ones_d = 4'd0;
            sec_tens_d = 4'd0;
            min_ones_d = 4'd0;
            min_tens_d = 4'd0;
        end else begin
            if ((state_q == ST_RUN) && tick_evt) begin
                if (tenths_q != 4'd9) begin
                    tenths_d = tenths_q + 4'd1;
                end else begin
                    tenths_d = 4'd0;
                    if (sec_ones_q != 4'd9) begin
                        sec_ones_d = sec_ones_q + 4'd1;
                    end else begin
                        sec_ones_d = 4'd0;
                        if (sec_tens_q != 4'd5) begin
                            sec_tens_d = sec_tens_q + 4'd1;
                        end else begin
                            sec_tens_d = 4'd0;
                            if ((min_tens_q == MIN_TENS_MAX) && (min_ones_q == MIN_ONES_MAX)) begin
                                min_tens_d = 4'd0;
                                min_ones_d = 4'd0;
                                wrap_d     = 1'b1;
                            end else if (min_ones_q != 4'd9) begin
                                min_ones_d = min_ones_q + 4'd1;
                            end else begin
                                min_ones_d = 4'd0;
                                min_tens_d = min_tens_q + 4'd1;
                            end
                        end
                    end
                end
            end else begin
                tenths_d = tenths_q;
            end
            if (start_evt) begin
                case (state_q)
                    ST_IDLE:  state_d = ST_RUN;
                    ST_RUN:   state_d = ST_PAUSE;
                    ST_PAUSE: state_d = ST_RUN;
                    default:  state_d = ST_IDLE;
                endcase
            end else begin
                state_d = state_q;
            end
        end
    end

    // State, digit, wrap and running registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            tenths_q   <= 4'd0;
            sec_ones_q <= 4'd0;
            sec_tens_q <= 4'd0;
            min_ones_q <= 4'd0;
            min_tens_q <= 4'd0;
            wrap_q     <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tenths_q   <= tenths_d;
            sec_ones_q <= sec_ones_d;
            sec_tens_q <= sec_tens_d;
            min_ones_q <= min_ones_d;
            min_tens_q <= min_tens_d;
            wrap_q     <= wrap_d;
            running_q  <= (state_d == ST_RUN);
        end
    end

    assign tenths   = tenths_q;
    assign sec_ones = sec_ones_q;
    assign sec_tens = sec_tens_q;
    assign min_ones = min_ones_q;
    assign min_tens = min_tens_q;
    assign running  = running_q;
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core: drives two stopwatch instances (SYNC_STAGES=2/MIN_LIMIT=59
// and SYNC_STAGES=3/MIN_LIMIT=2) with shared inputs and compares them against
// a model that keeps the elapsed time as a plain count of tenths.
module tb_stopwatch_core;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick_in;
    logic       btn_start;
    logic       btn_clear;
    logic [3:0] a_ten, a_so, a_st, a_mo, a_mt;
    logic [3:0] b_ten, b_so, b_st, b_mo, b_mt;
    logic       a_run, a_wrap, b_run, b_wrap;

    stopwatch_core #(.SYNC_STAGES(2), .MIN_LIMIT(59)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .tick_in(tick_in), .btn_start(btn_start), .btn_clear(btn_clear),
        .tenths(a_ten), .sec_ones(a_so), .sec_tens(a_st), .min_ones(a_mo), .min_tens(a_mt),
        .running(a_run), .wrap(a_wrap)
    );

    stopwatch_core #(.SYNC_STAGES(3), .MIN_LIMIT(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .tick_in(tick_in), .btn_start(btn_start), .btn_clear(btn_clear),
        .tenths(b_ten), .sec_ones(b_so), .sec_tens(b_st), .min_ones(b_mo), .min_tens(b_mt),
        .running(b_run), .wrap(b_wrap)
    );

    always #5 clk = ~clk;

    localparam int LIM_A = 60 * 600;
    localparam int LIM_B = 3 * 600;

    int checks = 0;
    int errors = 0;
    int m_state = 0;            // 0 idle, 1 run, 2 pause
    int cnt_a = 0, cnt_b = 0;   // elapsed tenths
    int exp_wrap_a = 0, exp_wrap_b = 0;
    int wrap_a_n = 0, wrap_b_n = 0, wrap_long = 0, wrap_bad = 0;
    logic a_wrap_prev = 1'b0, b_wrap_prev = 1'b0;

    wire [19:0] a_dig = {a_mt, a_mo, a_st, a_so, a_ten};
    wire [19:0] b_dig = {b_mt, b_mo, b_st, b_so, b_ten};

    // Wrap pulse monitor: counts pulses, flags pulses longer than one cycle or with nonzero digits.
    always @(negedge clk) begin
        if (a_wrap === 1'b1) begin
            wrap_a_n <= wrap_a_n + 1;
            if (a_wrap_prev) wrap_long <= wrap_long + 1;
            if (a_dig != 20'h0) wrap_bad <= wrap_bad + 1;
        end
        if (b_wrap === 1'b1) begin
            wrap_b_n <= wrap_b_n + 1;
            if (b_wrap_prev) wrap_long <= wrap_long + 1;
            if (b_dig != 20'h0) wrap_bad <= wrap_bad + 1;
        end
        a_wrap_prev <= a_wrap;
        b_wrap_prev <= b_wrap;
    end

    function automatic logic [19:0] to_bcd(input int c);
        int m, s;
        m = c / 600;
        s = (c / 10) % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c % 10)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference rules: clear first, then count in pre-edge RUN, then start toggle.
    task automatic m_apply(input logic t, input logic s, input logic c);
        if (c) begin
            m_state = 0;
            cnt_a = 0;
            cnt_b = 0;
        end else begin
            if (m_state == 1 && t) begin
                cnt_a++;
                if (cnt_a == LIM_A) begin cnt_a = 0; exp_wrap_a++; end
                cnt_b++;
                if (cnt_b == LIM_B) begin cnt_b = 0; exp_wrap_b++; end
            end
            if (s) m_state = (m_state == 1) ? 2 : 1;
        end
    endtask

    task automatic check_all(input string tag);
        #1;
        chk({tag, " a_digits"}, {12'h0, a_dig}, {12'h0, to_bcd(cnt_a)});
        chk({tag, " b_digits"}, {12'h0, b_dig}, {12'h0, to_bcd(cnt_b)});
        chk({tag, " a_running"}, {31'h0, a_run}, {31'h0, 1'(m_state == 1)});
        chk({tag, " b_running"}, {31'h0, b_run}, {31'h0, 1'(m_state == 1)});
        chk({tag, " a_wraps"}, wrap_a_n, exp_wrap_a);
        chk({tag, " b_wraps"}, wrap_b_n, exp_wrap_b);
        chk({tag, " wrap_shape"}, wrap_long + wrap_bad, 32'd0);
    endtask

    // One pulse on the selected inputs, held two cycles, then enough idle time for both instances.
    task automatic pulse(input logic t, input logic s, input logic c);
        @(negedge clk);
        tick_in = t; btn_start = s; btn_clear = c;
        @(negedge clk);
        @(negedge clk);
        tick_in = 1'b0; btn_start = 1'b0; btn_clear = 1'b0;
        @(negedge clk);
        @(negedge clk);
        m_apply(t, s, c);
    endtask

    task automatic fast_ticks(input int n);
        repeat (n) begin
            @(negedge clk);
            tick_in = 1'b1;
            m_apply(1'b1, 1'b0, 1'b0);
            @(negedge clk);
            tick_in = 1'b0;
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; tick_in = 1'b0; btn_start = 1'b0; btn_clear = 1'b0;
        repeat (2) @(negedge clk);
        check_all("reset");
        chk("reset a_wrap", {31'h0, a_wrap}, 32'd0);
        chk("reset b_wrap", {31'h0, b_wrap}, 32'd0);
        rst_n = 1'b1;

        // Start, then first tick with exact latency per synchronizer depth.
        pulse(1'b0, 1'b1, 1'b0);
        check_all("start");
        @(negedge clk); tick_in = 1'b1;       // rises before edge k
        @(negedge clk);                       // after edge k
        @(negedge clk); tick_in = 1'b0;       // after edge k+1
        #1 chk("lat a k+1", {12'h0, a_dig}, 32'h0);
        @(negedge clk);                       // after edge k+2
        #1 chk("lat a k+2", {12'h0, a_dig}, 32'h1);
        chk("lat b k+2", {12'h0, b_dig}, 32'h0);
        @(negedge clk);                       // after edge k+3
        #1 chk("lat b k+3", {12'h0, b_dig}, 32'h1);
        m_apply(1'b1, 1'b0, 1'b0);
        repeat (9) pulse(1'b1, 1'b0, 1'b0);
        check_all("00:01.0");

        // Seconds into minutes carry.
        fast_ticks(589);
        check_all("00:59.9");
        pulse(1'b1, 1'b0, 1'b0);
        check_all("01:00.0");

        // Rollover of the small instance at 02:59.9.
        fast_ticks(1199);
        check_all("02:59.9");
        pulse(1'b1, 1'b0, 1'b0);
        check_all("wrap_b");

        // Pause holds, resume continues.
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b0, 1'b1, 1'b0);
        fast_ticks(34);
        check_all("00:03.4");
        pulse(1'b0, 1'b1, 1'b0);
        repeat (5) pulse(1'b1, 1'b0, 1'b0);
        check_all("paused");
        pulse(1'b0, 1'b1, 1'b0);
        repeat (2) pulse(1'b1, 1'b0, 1'b0);
        check_all("00:03.6");

        // Tick and clear together while running at 00:07.2.
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b0, 1'b1, 1'b0);
        fast_ticks(72);
        check_all("00:07.2");
        pulse(1'b1, 1'b0, 1'b1);
        check_all("tick+clear");
        pulse(1'b1, 1'b0, 1'b0);
        check_all("idle tick");

        // Tick coinciding with start: counted in RUN, ignored in IDLE/PAUSE.
        pulse(1'b1, 1'b1, 1'b0);
        check_all("tick+start idle");
        pulse(1'b1, 1'b1, 1'b0);
        check_all("tick+start run");
        pulse(1'b1, 1'b1, 1'b0);
        check_all("tick+start pause");

        // Randomized mix of events, including coincidences and bursts.
        for (int i = 0; i < 150; i++) begin
            logic t, s, c;
            t = 1'($urandom_range(0, 1));
            s = ($urandom_range(0, 3) == 0);
            c = ($urandom_range(0, 15) == 0);
            pulse(t, s, c);
            if ($urandom_range(0, 7) == 0) fast_ticks(int'($urandom_range(1, 40)));
            check_all("random");
        end

        // Asynchronous reset mid-count at 00:12.5.
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b0, 1'b1, 1'b0);
        fast_ticks(125);
        check_all("00:12.5");
        @(negedge clk);
        #1 rst_n = 1'b0;
        m_state = 0; cnt_a = 0; cnt_b = 0;
        check_all("async reset");
        chk("async reset a_wrap", {31'h0, a_wrap}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulse(1'b1, 1'b0, 1'b0);
        check_all("post-reset tick");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
